// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO offsets, STATUS bit
// positions and the address bit that selects the MMIO region.
package dmem_pkg;

    localparam int REGION_BIT = 31;
    localparam logic REGION_MMIO = 1'b1;

    localparam logic [7:0] OFF_LED     = 8'h00;
    localparam logic [7:0] OFF_TXDATA  = 8'h04;
    localparam logic [7:0] OFF_STATUS  = 8'h08;
    localparam logic [7:0] OFF_CYCLE   = 8'h0C;
    localparam logic [7:0] OFF_COMPARE = 8'h10;

    localparam int STAT_FULL     = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_EXPIRED  = 2;
    localparam int STAT_OVERFLOW = 3;

endpackage

// File: rtl/dmem_tx_fifo.sv
// Byte FIFO feeding the output stream; a push while full is accepted only
// when a pop happens on the same edge.
module dmem_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW:0]   count_r;
    logic          accept_s;
    logic          do_pop_s;

    assign full     = (count_r == (PW+1)'(DEPTH));
    assign empty    = (count_r == {(PW+1){1'b0}});
    assign count    = count_r;
    assign do_pop_s = pop & ~empty;
    assign accept_s = push & (~full | do_pop_s);
    assign dout     = empty ? 8'h00 : mem_r[rd_ptr_r];

    // Storage write; when full with a pop, the freed head slot is the tail slot.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({accept_s, do_pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage responder: word RAM plus MMIO bank (LED, TX FIFO, STATUS, timer).
// Define DMEM_TIMER_EN to build the CYCLE/COMPARE timer and the expired flag.
module dmem_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  led,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data
);
    import dmem_pkg::*;

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram_r [RAM_WORDS];
    logic [AW-1:0] ram_idx_s;
    logic          is_mmio_s;
    logic [7:0]    off_s;
    logic          mmio_we_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic          stat_we_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    logic          overflow_r;
    logic          expired_s;
    logic [31:0]   cycle_s;
    logic [31:0]   compare_s;
    logic [31:0]   status_s;
    logic          unused_s;

    assign ram_idx_s = Addr[AW+1:2];
    assign is_mmio_s = (Addr[REGION_BIT] == REGION_MMIO);
    assign off_s     = {Addr[7:2], 2'b00};
    assign mmio_we_s = MemWrite & is_mmio_s;
    assign push_s    = mmio_we_s & (off_s == OFF_TXDATA);
    assign stat_we_s = mmio_we_s & (off_s == OFF_STATUS);
    assign out_valid = ~empty_s;
    assign pop_s     = out_valid & out_ready;
    assign drop_s    = push_s & full_s & ~pop_s;
    assign unused_s  = &{1'b0, Addr};

    dmem_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (WriteData[7:0]),
        .dout  (out_data),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Data RAM store port; contents intentionally not reset.
    always_ff @(posedge clk) begin
        if (MemWrite && !is_mmio_s) begin
            ram_r[ram_idx_s] <= WriteData;
        end
    end

    // LED register and sticky overflow flag; a new drop beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            led        <= 8'h00;
            overflow_r <= 1'b0;
        end else begin
            if (mmio_we_s && (off_s == OFF_LED)) begin
                led <= WriteData[7:0];
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (stat_we_s && WriteData[STAT_OVERFLOW]) begin
                overflow_r <= 1'b0;
            end
        end
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] cycle_r;
    logic [31:0] compare_r;
    logic        expired_r;
    logic        hit_s;

    assign hit_s     = (cycle_r == compare_r) && (compare_r != 32'h0);
    assign cycle_s   = cycle_r;
    assign compare_s = compare_r;
    assign expired_s = expired_r;

    // Free-running cycle counter, compare register and sticky expired flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_r   <= 32'h0;
            compare_r <= 32'h0;
            expired_r <= 1'b0;
        end else begin
            if (mmio_we_s && (off_s == OFF_CYCLE)) begin
                cycle_r <= 32'h0;
            end else begin
                cycle_r <= cycle_r + 32'd1;
            end
            if (mmio_we_s && (off_s == OFF_COMPARE)) begin
                compare_r <= WriteData;
            end
            if (hit_s) begin
                expired_r <= 1'b1;
            end else if (stat_we_s && WriteData[STAT_EXPIRED]) begin
                expired_r <= 1'b0;
            end
        end
    end
`else
    assign cycle_s   = 32'h0;
    assign compare_s = 32'h0;
    assign expired_s = 1'b0;
`endif

    assign status_s = {16'h0000, 8'(count_s), 4'h0, overflow_r, expired_s, empty_s, full_s};

    // Combinational load path: RAM or MMIO register selected by address.
    always_comb begin
        ReadData = 32'h0;
        if (!is_mmio_s) begin
            ReadData = ram_r[ram_idx_s];
        end else begin
            case (off_s)
                OFF_LED:     ReadData = {24'h000000, led};
                OFF_STATUS:  ReadData = status_s;
                OFF_CYCLE:   ReadData = cycle_s;
                OFF_COMPARE: ReadData = compare_s;
                default:     ReadData = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default RAM_WORDS=64, FIFO_DEPTH=4).
module tb_dmem_responder;

    localparam logic [31:0] A_LED     = 32'h8000_0000;
    localparam logic [31:0] A_TX      = 32'h8000_0004;
    localparam logic [31:0] A_STATUS  = 32'h8000_0008;
    localparam logic [31:0] A_CYCLE   = 32'h8000_000C;
    localparam logic [31:0] A_COMPARE = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  led;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .led       (led),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr      = a;
        WriteData = d;
        MemWrite  = 1'b1;
        step();
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = ReadData;
    endtask

    logic [31:0] d;
    int          n;

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        Addr      = 32'h0;
        WriteData = 32'h0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        check("rst_led", {24'h0, led}, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_data", {24'h0, out_data}, 32'h0);
        rd(A_STATUS, d);
        check("rst_status", d, 32'h0000_0002);

        // RAM store/load, byte-offset ignore and aliasing
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        wr(32'h0000_0014, 32'h1234_5678);
        rd(32'h0000_0010, d);
        check("ram_rd", d, 32'hDEAD_BEEF);
        rd(32'h0000_0013, d);
        check("ram_rd_lowbits", d, 32'hDEAD_BEEF);
        rd(32'h0000_0110, d);
        check("ram_alias", d, 32'hDEAD_BEEF);
        rd(32'h0000_0014, d);
        check("ram_rd2", d, 32'h1234_5678);

        // LED, unlisted and write-only offsets
        wr(A_LED, 32'h0000_01A5);
        check("led_out", {24'h0, led}, 32'h0000_00A5);
        rd(A_LED, d);
        check("led_rd", d, 32'h0000_00A5);
        rd(32'h8000_0020, d);
        check("unlisted_rd", d, 32'h0);
        rd(A_TX, d);
        check("tx_rd", d, 32'h0);

        // Two bytes queued then drained
        wr(A_TX, 32'h48);
        check("push_valid", {31'h0, out_valid}, 32'h1);
        wr(A_TX, 32'h69);
        rd(A_STATUS, d);
        check("two_status", d, 32'h0000_0200);
        check("head_48", {24'h0, out_data}, 32'h48);
        step();
        check("head_held", {24'h0, out_data}, 32'h48);
        out_ready = 1'b1;
        #1;
        check("deliver_48", {24'h0, out_data}, 32'h48);
        step();
        check("deliver_69", {24'h0, out_data}, 32'h69);
        step();
        check("drained_valid", {31'h0, out_valid}, 32'h0);
        out_ready = 1'b0;
        rd(A_STATUS, d);
        check("drained_status", d, 32'h0000_0002);

        // Overflow: five pushes into four entries
        for (int i = 1; i <= 5; i++) begin
            wr(A_TX, 32'(i));
        end
        rd(A_STATUS, d);
        check("ovf_status", d, 32'h0000_0409);
        check("ovf_head", {24'h0, out_data}, 32'h01);
        wr(A_STATUS, 32'h8);
        rd(A_STATUS, d);
        check("ovf_clear", d, 32'h0000_0401);

        // Push while full with a simultaneous pop
        out_ready = 1'b1;
        wr(A_TX, 32'h66);
        rd(A_STATUS, d);
        check("fullpp_status", d, 32'h0000_0401);
        check("fullpp_head", {24'h0, out_data}, 32'h02);
        step();
        check("seq_03", {24'h0, out_data}, 32'h03);
        step();
        check("seq_04", {24'h0, out_data}, 32'h04);
        step();
        check("seq_66", {24'h0, out_data}, 32'h66);
        step();
        check("seq_end_valid", {31'h0, out_valid}, 32'h0);
        check("seq_end_data", {24'h0, out_data}, 32'h0);
        out_ready = 1'b0;

`ifdef DMEM_TIMER_EN
        wr(A_COMPARE, 32'd20);
        rd(A_COMPARE, d);
        check("cmp_rd", d, 32'd20);
        wr(A_CYCLE, 32'h0);
        rd(A_CYCLE, d);
        check("cycle_zero", d, 32'h0);
        rd(A_STATUS, d);
        check("exp_clear0", {31'h0, d[2]}, 32'h0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            rd(A_STATUS, d);
            if (d[2]) break;
        end
        check("exp_latency", n, 32'd21);
        rd(A_CYCLE, d);
        check("cycle_cnt", d, 32'd21);
        for (int i = 0; i < 5; i++) step();
        rd(A_STATUS, d);
        check("exp_sticky", {31'h0, d[2]}, 32'h1);
        wr(A_STATUS, 32'h4);
        rd(A_STATUS, d);
        check("exp_cleared", {31'h0, d[2]}, 32'h0);
`else
        wr(A_CYCLE, 32'd5);
        rd(A_CYCLE, d);
        check("cycle_off", d, 32'h0);
        wr(A_COMPARE, 32'd20);
        rd(A_COMPARE, d);
        check("cmp_off", d, 32'h0);
        for (int i = 0; i < 25; i++) step();
        rd(A_STATUS, d);
        check("exp_off", {31'h0, d[2]}, 32'h0);
`endif

        // Reset in the middle of pending output
        wr(A_LED, 32'h0000_01A5);
        wr(A_TX, 32'h11);
        wr(A_TX, 32'h22);
        check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_led", {24'h0, led}, 32'h0);
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_data", {24'h0, out_data}, 32'h0);
        rd(A_STATUS, d);
        check("mid_rst_status", d, 32'h0000_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder sitting on the far side of the core's memory-stage port (write-enable, address, write data, read data). Decodes every access into a word-addressed data RAM or a small MMIO bank (LED register, cycle counter/compare timer, byte output FIFO drained over a valid/ready stream). The core has no memory stall, so reads return combinationally in the same cycle as the address; all state updates on the rising clock edge.

## Interface
- RAM_WORDS, 64, data RAM depth in 32-bit words (power of 2)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)
- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- MemWrite  in  1  write strobe for current address
- Addr  in  32  byte address; Addr[1:0] ignored
- WriteData  in  32  store data
- ReadData  out  32  load data, combinational from Addr
- led  out  8  LED register
- out_valid  out  1  FIFO head valid
- out_ready  in  1  sink accepts head
- out_data  out  8  FIFO head byte; 0 when empty

## Operation
- Addr[31]=0: RAM, index Addr[log2(RAM_WORDS)+1:2], upper bits aliased. Read combinational; write at posedge when MemWrite. RAM contents not reset.
- Addr[31]=1: MMIO, offset Addr[7:0]; unlisted offsets read 0, writes ignored.
- 0x00 LED: RW, bits[7:0]; upper bits read 0.
- 0x04 TXDATA: write pushes WriteData[7:0]; reads 0.
- 0x08 STATUS (R): bit0 full, bit1 empty, bit2 timer expired, bit3 overflow (sticky), [15:8] FIFO count. Write: 1 to bit2 clears expired, 1 to bit3 clears overflow; other bits ignored.
- 0x0C CYCLE: R free-running 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF→0. Write clears to 0 (counter reads 0 in the next cycle, then counts).
- 0x10 COMPARE: RW 32-bit. Expired set when CYCLE==COMPARE and COMPARE≠0; sticky until cleared. Set and clear in same cycle: set wins.
- FIFO: pop when out_valid & out_ready. Push when not full, or full with simultaneous pop (count unchanged). Push while full without pop: byte dropped, overflow set. Push+pop while non-empty, non-full: count unchanged. out_data stable while out_valid & !out_ready.

## Timing
- Reset values: led=0, out_valid=0, out_data=0, CYCLE=0, COMPARE=0, expired=0, overflow=0, FIFO empty, pointers 0. ReadData purely combinational (RAM reads undefined until written).
- Load latency 0 cycles (same-cycle as Addr). Store visible to a read in the following cycle.
- Push into empty FIFO: out_valid=1 the cycle after the write edge.
- Pop of last entry: out_valid=0 the cycle after the handshake edge.
- STATUS reflects state registered at the previous edge; a push in cycle N shows in count at N+1.
- Reset asserted mid-stream: FIFO flushed, out_valid drops at the reset edge; no partial byte delivered.

## Configuration
- DMEM_TIMER_EN defined: CYCLE, COMPARE, expired bit implemented as above.
- Undefined: CYCLE and COMPARE read 0, writes ignored, STATUS bit2 always 0, no counter flops synthesised.

## Structure
- Package dmem_pkg: MMIO offset constants (OFF_LED, OFF_TXDATA, OFF_STATUS, OFF_CYCLE, OFF_COMPARE), STATUS bit index constants, Addr[31] region-select constant.
- One sub-module: dmem_tx_fifo (parameterised FIFO_DEPTH, push/pop, full/empty/count, head data); dmem_responder holds RAM, decode, LED and timer.

## Test plan
- Store 0xDEADBEEF to 0x00000010, load 0x00000010 and 0x00000013 next cycle -> ReadData=0xDEADBEEF both.
- Write 0x48,0x69 to 0x80000004 with out_ready=0 -> STATUS[15:8]=2, out_data=0x48 held; raise out_ready -> 0x48 then 0x69 delivered, out_valid=0, STATUS bit1=1.
- Five pushes into FIFO_DEPTH=4 with out_ready=0 -> count=4, bit0=1, bit3=1, fifth byte never appears; write 0x8 to STATUS -> bit3=0.
- Push while full with out_ready=1 same cycle -> count stays 4, pushed byte appears after three further pops.
- DMEM_TIMER_EN: write COMPARE=20, write CYCLE -> bit2 sets when CYCLE=20, stays set; write 0x4 to STATUS -> clears. Without macro -> CYCLE reads 0, bit2 0.
- Write LED=0x1A5, pushes pending, assert reset one cycle -> led=0, out_valid=0, STATUS=0x00000002.
